// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID register: one outstanding imem request,
// a one-entry hold buffer for decode stalls, and branch / PC-write redirects.
module fetch_stage #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [WIDTH-1:0] BUBBLE   = 32'hEC00_0000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             StallF,
   input  logic             StallD,
   input  logic             FlushD,
   input  logic             BranchTakenE,
   input  logic [WIDTH-1:0] ALUResultE,
   input  logic             PCSrcW,
   input  logic [WIDTH-1:0] ResultW,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_valid,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic [WIDTH-1:0] PCF,
   output logic [WIDTH-1:0] InstrD,
   output logic [WIDTH-1:0] PCPlus8D,
   output logic             InstrValidD,
   output logic [3:0]       CondD,
   output logic [1:0]       OpD,
   output logic [5:0]       FunctD,
   output logic [3:0]       RdD,
   output logic             FetchBusyF
);

   // state   | meaning
   // S_FETCH | idle, may issue a request at PCF
   // S_WAIT  | request outstanding, its response will be used
   // S_DROP  | request outstanding, its response is stale and discarded
   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_DROP  = 2'd2;

   logic [1:0]       state;
   logic [1:0]       stateNext;
   logic             bufValid;
   logic [WIDTH-1:0] bufInstr;
   logic [WIDTH-1:0] bufPc;
   logic             redirect;
   logic [WIDTH-1:0] target;
   logic             accept;
   logic             toBuf;

   assign redirect  = BranchTakenE | PCSrcW;
   assign target    = BranchTakenE ? ALUResultE : ResultW;
   assign imem_req  = ~reset & (state == S_FETCH) & ~StallF & ~bufValid & ~redirect;
   assign imem_addr = PCF;

   // A response that coincides with a redirect belongs to the old path.
   assign accept = (state == S_WAIT) & imem_valid & ~redirect;
   assign toBuf  = accept & (StallD | bufValid);

   assign FetchBusyF = ~bufValid & ~((state == S_WAIT) & imem_valid);

   assign CondD  = InstrD[31:28];
   assign OpD    = InstrD[27:26];
   assign FunctD = InstrD[25:20];
   assign RdD    = InstrD[15:12];

   always_comb begin
      stateNext = state;
      case (state)
         S_FETCH: if (imem_req) stateNext = S_WAIT;
         S_WAIT: begin
            if (imem_valid)    stateNext = S_FETCH;
            else if (redirect) stateNext = S_DROP;
         end
         S_DROP:  if (imem_valid) stateNext = S_FETCH;
         default: stateNext = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_FETCH;
         PCF   <= RESET_PC;
      end else begin
         state <= stateNext;
         if (redirect)
            PCF <= target;
         else if (accept)
            PCF <= PCF + WIDTH'(4);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bufValid <= 1'b0;
         bufInstr <= BUBBLE;
         bufPc    <= '0;
      end else if (redirect) begin
         bufValid <= 1'b0;
      end else if (toBuf) begin
         bufValid <= 1'b1;
         bufInstr <= imem_rdata;
         bufPc    <= PCF;
      end else if (~StallD & bufValid) begin
         // Drained into IF/ID, or consumed by a flush.
         bufValid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         InstrD      <= BUBBLE;
         PCPlus8D    <= '0;
         InstrValidD <= 1'b0;
      end else if (~StallD) begin
         if (FlushD) begin
            InstrD      <= BUBBLE;
            InstrValidD <= 1'b0;
         end else if (bufValid) begin
            InstrD      <= bufInstr;
            PCPlus8D    <= bufPc + WIDTH'(8);
            InstrValidD <= 1'b1;
         end else if (accept) begin
            InstrD      <= imem_rdata;
            PCPlus8D    <= PCF + WIDTH'(8);
            InstrValidD <= 1'b1;
         end else begin
            InstrD      <= BUBBLE;
            InstrValidD <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-configurable imem model returns
// address-tagged words; every expected value is hand-derived.
module tb_fetch_stage;

   localparam logic [31:0] BUB = 32'hEC00_0000;

   logic        clk;
   logic        reset;
   logic        StallF, StallD, FlushD;
   logic        BranchTakenE, PCSrcW;
   logic [31:0] ALUResultE, ResultW;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic [31:0] PCF, InstrD, PCPlus8D;
   logic        InstrValidD;
   logic [3:0]  CondD;
   logic [1:0]  OpD;
   logic [5:0]  FunctD;
   logic [3:0]  RdD;
   logic        FetchBusyF;

   int          tests = 0;
   int          fails = 0;
   int          memLat = 1;
   int          pendCnt = 0;
   logic [31:0] pendAddr = '0;

   fetch_stage dut (
      .clk(clk), .reset(reset),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE),
      .PCSrcW(PCSrcW), .ResultW(ResultW),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_rdata(imem_rdata),
      .PCF(PCF), .InstrD(InstrD), .PCPlus8D(PCPlus8D), .InstrValidD(InstrValidD),
      .CondD(CondD), .OpD(OpD), .FunctD(FunctD), .RdD(RdD),
      .FetchBusyF(FetchBusyF)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] tag(input logic [31:0] a);
      return {8'hE2, a[23:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   // One clock: sample the request, take the edge, then update the memory model.
   task automatic cyc();
      logic        req;
      logic [31:0] addr;
      #1;
      req  = imem_req;
      addr = imem_addr;
      @(posedge clk);
      #1;
      imem_valid = 1'b0;
      if (req) begin
         pendAddr = addr;
         pendCnt  = memLat;
      end
      if (pendCnt != 0) begin
         pendCnt--;
         if (pendCnt == 0) begin
            imem_valid = 1'b1;
            imem_rdata = tag(pendAddr);
         end
      end
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      StallF = 0; StallD = 0; FlushD = 0;
      BranchTakenE = 0; PCSrcW = 0; ALUResultE = '0; ResultW = '0;
      imem_valid = 0; imem_rdata = '0;
      #1 reset = 1'b1;
      #1;
      chk("rst_req",    {31'b0, imem_req}, 32'd0);
      chk("rst_pcf",    PCF, 32'h0);
      chk("rst_instr",  InstrD, BUB);
      chk("rst_valid",  {31'b0, InstrValidD}, 32'd0);
      chk("rst_pc8",    PCPlus8D, 32'h0);
      cyc();
      chk("rst_req_clk", {31'b0, imem_req}, 32'd0);
      cyc();
      reset = 1'b0;
      #1;
      chk("rel_req",  {31'b0, imem_req}, 32'd1);
      chk("rel_addr", imem_addr, 32'h0);

      // request 0, response next cycle
      cyc();
      chk("w0_busy", {31'b0, FetchBusyF}, 32'd0);
      chk("w0_noreq", {31'b0, imem_req}, 32'd0);
      cyc();
      chk("w0_instr", InstrD, tag(32'h0));
      chk("w0_pc8",   PCPlus8D, 32'h8);
      chk("w0_valid", {31'b0, InstrValidD}, 32'd1);
      chk("a4_addr",  imem_addr, 32'h4);
      chk("a4_busy",  {31'b0, FetchBusyF}, 32'd1);

      // decode stall for three edges while word@4 returns
      StallD = 1;
      cyc();
      chk("st_hold1", InstrD, tag(32'h0));
      chk("st_noreq1", {31'b0, imem_req}, 32'd0);
      cyc();
      chk("st_buf_noreq", {31'b0, imem_req}, 32'd0);
      chk("st_buf_busy",  {31'b0, FetchBusyF}, 32'd0);
      chk("st_pcf",       PCF, 32'h8);
      chk("st_hold2",     InstrD, tag(32'h0));
      cyc();
      chk("st_noreq3", {31'b0, imem_req}, 32'd0);
      chk("st_hold3",  InstrD, tag(32'h0));
      StallD = 0;
      cyc();
      chk("st_drain_instr", InstrD, tag(32'h4));
      chk("st_drain_pc8",   PCPlus8D, 32'hC);
      chk("st_drain_valid", {31'b0, InstrValidD}, 32'd1);
      chk("st_resume_req",  {31'b0, imem_req}, 32'd1);
      chk("st_resume_addr", imem_addr, 32'h8);

      // branch while waiting on a slow response for 0x8
      memLat = 3;
      cyc();
      chk("br_bubble", {31'b0, InstrValidD}, 32'd0);
      chk("br_busy",   {31'b0, FetchBusyF}, 32'd1);
      BranchTakenE = 1; ALUResultE = 32'h100;
      #1;
      chk("br_noreq", {31'b0, imem_req}, 32'd0);
      cyc();
      BranchTakenE = 0;
      chk("br_pcf",       PCF, 32'h100);
      chk("br_drop_noreq", {31'b0, imem_req}, 32'd0);
      cyc();
      chk("br_drop_busy", {31'b0, FetchBusyF}, 32'd1);
      chk("br_drop_req",  {31'b0, imem_req}, 32'd0);
      cyc();
      chk("br_no_w8",    InstrD, BUB);
      chk("br_no_w8_v",  {31'b0, InstrValidD}, 32'd0);
      chk("br_next_req", {31'b0, imem_req}, 32'd1);
      chk("br_next_addr", imem_addr, 32'h100);
      memLat = 1;
      cyc();
      cyc();
      chk("br_w100",     InstrD, tag(32'h100));
      chk("br_w100_pc8", PCPlus8D, 32'h108);
      chk("br_pcf2",     PCF, 32'h104);

      // StallF blocks requests; simultaneous redirects, branch wins over StallF too
      StallF = 1;
      #1;
      chk("sf_noreq", {31'b0, imem_req}, 32'd0);
      BranchTakenE = 1; ALUResultE = 32'h200;
      PCSrcW = 1; ResultW = 32'h300;
      cyc();
      BranchTakenE = 0; PCSrcW = 0; StallF = 0;
      #1;
      chk("prio_pcf",  PCF, 32'h200);
      chk("prio_addr", imem_addr, 32'h200);
      chk("prio_req",  {31'b0, imem_req}, 32'd1);

      // flush held by StallD, then applied
      cyc();
      cyc();
      chk("fl_w200",   InstrD, tag(32'h200));
      chk("fl_cond",   {28'b0, CondD}, 32'hE);
      chk("fl_funct",  {26'b0, FunctD}, 32'h20);
      chk("fl_op0",    {30'b0, OpD}, 32'h0);
      StallD = 1; FlushD = 1;
      cyc();
      chk("fl_stall_hold",  InstrD, tag(32'h200));
      chk("fl_stall_valid", {31'b0, InstrValidD}, 32'd1);
      StallD = 0;
      cyc();
      FlushD = 0;
      chk("fl_instr", InstrD, BUB);
      chk("fl_op",    {30'b0, OpD}, 32'h3);
      chk("fl_cond2", {28'b0, CondD}, 32'hE);
      chk("fl_valid", {31'b0, InstrValidD}, 32'd0);
      chk("fl_pcf",   PCF, 32'h208);

      // PC wraps at the top of the address space
      BranchTakenE = 1; ALUResultE = 32'hFFFF_FFFC;
      cyc();
      BranchTakenE = 0;
      cyc();
      cyc();
      chk("wrap_instr", InstrD, tag(32'hFFFF_FFFC));
      chk("wrap_pcf",   PCF, 32'h0);
      chk("wrap_pc8",   PCPlus8D, 32'h4);

      // asynchronous reset while waiting at 0x40
      PCSrcW = 1; ResultW = 32'h40;
      cyc();
      PCSrcW = 0;
      memLat = 3;
      cyc();
      chk("ar_addr", imem_addr, 32'h40);
      chk("ar_busy", {31'b0, FetchBusyF}, 32'd1);
      reset = 1'b1;
      pendCnt = 0;
      imem_valid = 1'b0;
      #1;
      chk("ar_pcf",   PCF, 32'h0);
      chk("ar_instr", InstrD, BUB);
      chk("ar_valid", {31'b0, InstrValidD}, 32'd0);
      chk("ar_pc8",   PCPlus8D, 32'h0);
      chk("ar_req",   {31'b0, imem_req}, 32'd0);
      cyc();
      memLat = 1;
      reset = 1'b0;
      #1;
      chk("ar_rel_req",  {31'b0, imem_req}, 32'd1);
      chk("ar_rel_addr", imem_addr, 32'h0);
      cyc();
      cyc();
      chk("ar_w0",   InstrD, tag(32'h0));
      chk("ar_pc8b", PCPlus8D, 32'h8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
